// File: rtl/lib_cpu.sv
// ---------------------------------------------------------------------------
// lib_cpu: shared CPU pipeline types.
//   EXECUTE      - record handed from execute to writeback (one per commit).
//   SPECIAL_REG  - architectural special registers (pc, interrupt, UART status).
//   GENERAL_REG  - operand values returned to decode (x_rs1, x_rs2, mem_val).
//   UART_TX_BUF  - one-entry UART transmit buffer (valid + byte).
// ---------------------------------------------------------------------------
package lib_cpu;

  localparam int XLEN       = 32;
  localparam int REG_IDX_W  = 4;
  localparam int MEM_ADDR_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic                  w_rd;       // write x_rd to the register file
    logic [XLEN-1:0]       x_rd;
    logic                  mem_w_req;  // write mem_val to data memory
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]       mem_val;
    logic                  w_req;      // push w_data into the UART TX buffer
    logic [7:0]            w_data;
    logic                  ack;        // acknowledge the pending RX byte
    logic                  intr_en;
    logic [XLEN-1:0]       intr_pc;
    logic [7:0]            intr_vec;
  } EXECUTE;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            intr_en;
    logic [XLEN-1:0] intr_pc;
    logic [7:0]      intr_vec;
    logic            irr;      // RX byte pending
    logic [7:0]      r_data;   // last RX byte
    logic            w_busy;   // TX buffer occupied
  } SPECIAL_REG;

  typedef struct packed {
    logic [XLEN-1:0] x_rs1;
    logic [XLEN-1:0] x_rs2;
    logic [XLEN-1:0] mem_val;
  } GENERAL_REG;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } UART_TX_BUF;

endpackage

// File: rtl/cpu_regfile.sv
// ---------------------------------------------------------------------------
// cpu_regfile: NREG x 32 register file, two combinational read ports, one
// synchronous write port. Register 0 is hardwired to zero.
// Build option: CPU_WB_BYPASS_EN forwards the write data to a read port that
// addresses the register being written in the same cycle.
// Ports:
//   clk, rst_n        clock / async active-low reset (all registers zeroed)
//   we, waddr, wdata  write port (write to index 0 dropped)
//   raddr1, rdata1    read port 1
//   raddr2, rdata2    read port 2
// ---------------------------------------------------------------------------
module cpu_regfile
  import lib_cpu::*;
#(
  parameter int NREG = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2
);

  logic [XLEN-1:0] rf [NREG];

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we && waddr != '0) begin
      rf[waddr] <= wdata;
    end
  end

  // NOTE: every output of a combinational block gets a default on entry so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];
`ifdef CPU_WB_BYPASS_EN
    if (we && waddr != '0 && raddr1 == waddr) rdata1 = wdata;
    if (we && waddr != '0 && raddr2 == waddr) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/cpu_writeback.sv
// ---------------------------------------------------------------------------
// cpu_writeback: commit stage. Consumes one EXECUTE record per handshake and
// owns the architectural state: register file, data memory, special
// registers, one-entry UART TX buffer and the RX byte latch.
// Build option: CPU_WB_BYPASS_EN makes committing register/memory writes
// visible on gr in the commit cycle instead of the following one.
// Ports:
//   clk, rst_n                   clock / async active-low reset
//   ex_valid, ex_ready, ex       execute record handshake and payload
//   rd_idx                       destination register for ex
//   rs1_idx, rs2_idx, mem_raddr  decode read addresses
//   sr, gr                       special regs / operand values for decode
//   rx_valid, rx_data            UART RX byte strobe
//   tx_valid, tx_ready, tx_data  UART TX byte handshake
//   rx_overrun                   sticky RX overrun flag
// ---------------------------------------------------------------------------
module cpu_writeback
  import lib_cpu::*;
#(
  parameter int          NREG     = 16,
  parameter int          NMEM     = 64,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  EXECUTE                ex,
  input  logic [REG_IDX_W-1:0]  rd_idx,
  input  logic [REG_IDX_W-1:0]  rs1_idx,
  input  logic [REG_IDX_W-1:0]  rs2_idx,
  input  logic [MEM_ADDR_W-1:0] mem_raddr,
  output SPECIAL_REG            sr,
  output GENERAL_REG            gr,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  rx_overrun
);

  logic            commit;
  logic            tx_load;
  logic            tx_drain;
  logic            rx_ack;
  UART_TX_BUF      tx_buf_q;
  logic [XLEN-1:0] pc_q;
  logic            intr_en_q;
  logic [XLEN-1:0] intr_pc_q;
  logic [7:0]      intr_vec_q;
  logic            irr_q;
  logic [7:0]      r_data_q;
  logic            rx_overrun_q;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] mem [NMEM];

  // Stall only when this record wants the TX buffer and it is full and not
  // draining this cycle; independent of ex_valid.
  assign ex_ready = ~(ex.w_req & tx_buf_q.valid & ~tx_ready);
  assign commit   = ex_valid & ex_ready;
  assign tx_load  = commit & ex.w_req;
  assign tx_drain = tx_buf_q.valid & tx_ready;
  assign rx_ack   = commit & ex.ack;

  cpu_regfile #(.NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit & ex.w_rd),
    .waddr  (rd_idx),
    .wdata  (ex.x_rd),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // NOTE: the data memory has no reset; clearing a RAM needs a port per word
  // and software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    if (commit && ex.mem_w_req) mem[ex.mem_addr] <= ex.mem_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      intr_en_q  <= 1'b0;
      intr_pc_q  <= '0;
      intr_vec_q <= '0;
    end else if (commit) begin
      pc_q       <= ex.pc;
      intr_en_q  <= ex.intr_en;
      intr_pc_q  <= ex.intr_pc;
      intr_vec_q <= ex.intr_vec;
    end
  end

  // A load in the same cycle as a drain replaces the leaving byte, so valid
  // stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf_q <= '0;
    end else if (tx_load) begin
      tx_buf_q.valid <= 1'b1;
      tx_buf_q.data  <= ex.w_data;
    end else if (tx_drain) begin
      tx_buf_q.valid <= 1'b0;
    end
  end

  // A new byte beats a coincident ack. Overrun flags a byte that lands on an
  // unacknowledged one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr_q        <= 1'b0;
      r_data_q     <= '0;
      rx_overrun_q <= 1'b0;
    end else if (rx_valid) begin
      irr_q    <= 1'b1;
      r_data_q <= rx_data;
      if (irr_q && !rx_ack) rx_overrun_q <= 1'b1;
    end else if (rx_ack) begin
      irr_q <= 1'b0;
    end
  end

  assign tx_valid   = tx_buf_q.valid;
  assign tx_data    = tx_buf_q.data;
  assign rx_overrun = rx_overrun_q;

  always_comb begin
    sr          = '0;
    sr.pc       = pc_q;
    sr.intr_en  = intr_en_q;
    sr.intr_pc  = intr_pc_q;
    sr.intr_vec = intr_vec_q;
    sr.irr      = irr_q;
    sr.r_data   = r_data_q;
    sr.w_busy   = tx_buf_q.valid;
  end

  always_comb begin
    gr         = '0;
    gr.x_rs1   = rs1_val;
    gr.x_rs2   = rs2_val;
    gr.mem_val = mem[mem_raddr];
`ifdef CPU_WB_BYPASS_EN
    if (commit && ex.mem_w_req && mem_raddr == ex.mem_addr) gr.mem_val = ex.mem_val;
`endif
  end

endmodule

// File: tb/tb_cpu_writeback.sv
module tb_cpu_writeback;
  import lib_cpu::*;

  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef CPU_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       ex_valid;
  logic       ex_ready;
  EXECUTE     ex;
  logic [3:0] rd_idx, rs1_idx, rs2_idx;
  logic [5:0] mem_raddr;
  SPECIAL_REG sr;
  GENERAL_REG gr;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state as plain variables.
  logic [31:0] rf_m [16];
  logic [31:0] mem_m [64];
  bit          mem_known [64];
  logic [31:0] pc_m, intr_pc_m;
  logic        intr_en_m;
  logic [7:0]  intr_vec_m;
  logic        irr_m, ovr_m, txv_m;
  logic [7:0]  rdata_m, txd_m;

  cpu_writeback #(.NREG(16), .NMEM(64), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex         (ex),
    .rd_idx     (rd_idx),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .mem_raddr  (mem_raddr),
    .sr         (sr),
    .gr         (gr),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .rx_overrun (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit ready_m();
    return !(ex.w_req && txv_m && !tx_ready);
  endfunction

  function automatic bit commit_m();
    return ex_valid && ready_m();
  endfunction

  function automatic logic [31:0] exp_reg(input logic [3:0] idx);
    if (idx == 4'd0) return 32'h0;
    if (BYPASS && commit_m() && ex.w_rd && rd_idx == idx) return ex.x_rd;
    return rf_m[idx];
  endfunction

  function automatic bit mem_visible(input logic [5:0] a);
    return mem_known[a] || (BYPASS && commit_m() && ex.mem_w_req && ex.mem_addr == a);
  endfunction

  function automatic logic [31:0] exp_mem(input logic [5:0] a);
    if (BYPASS && commit_m() && ex.mem_w_req && ex.mem_addr == a) return ex.mem_val;
    return mem_m[a];
  endfunction

  function automatic SPECIAL_REG exp_sr();
    SPECIAL_REG s;
    s = '0;
    s.pc = pc_m; s.intr_en = intr_en_m; s.intr_pc = intr_pc_m; s.intr_vec = intr_vec_m;
    s.irr = irr_m; s.r_data = rdata_m; s.w_busy = txv_m;
    return s;
  endfunction

  task automatic model_reset();
    pc_m = RESET_PC; intr_en_m = 0; intr_pc_m = 0; intr_vec_m = 0;
    irr_m = 0; ovr_m = 0; rdata_m = 0; txv_m = 0; txd_m = 0;
    for (int i = 0; i < 16; i++) rf_m[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem_known[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    ex = '0; ex_valid = 0; rd_idx = 0; rs1_idx = 0; rs2_idx = 0;
    mem_raddr = 0; rx_valid = 0; rx_data = 0;
  endtask

  // Advance one clock edge, applying the architectural rules to the model
  // using the inputs present before the edge. Ends at the next falling edge
  // with the one-cycle strobes dropped.
  task automatic tick();
    bit c, ack, load, drain;
    c     = commit_m();
    ack   = c && ex.ack;
    load  = c && ex.w_req;
    drain = txv_m && tx_ready;
    @(posedge clk);
    if (c) begin
      if (ex.w_rd && rd_idx != 0) rf_m[rd_idx] = ex.x_rd;
      if (ex.mem_w_req) begin
        mem_m[ex.mem_addr] = ex.mem_val;
        mem_known[ex.mem_addr] = 1'b1;
      end
      pc_m = ex.pc; intr_en_m = ex.intr_en; intr_pc_m = ex.intr_pc; intr_vec_m = ex.intr_vec;
    end
    if (load) begin
      txv_m = 1; txd_m = ex.w_data;
    end else if (drain) begin
      txv_m = 0;
    end
    if (rx_valid) begin
      if (irr_m && !ack) ovr_m = 1;
      irr_m = 1; rdata_m = rx_data;
    end else if (ack) begin
      irr_m = 0;
    end
    @(negedge clk);
    ex_valid = 0;
    rx_valid = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sr.pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", sr.pc, RESET_PC); end
    checks++; if ({sr.intr_en, sr.intr_pc, sr.intr_vec, sr.irr, sr.r_data, sr.w_busy} !== '0) begin
      errors++; $display("FAIL reset_sr got %h exp 0", sr); end
    checks++; if ({tx_valid, tx_data, rx_overrun} !== 10'h0) begin
      errors++; $display("FAIL reset_uart got %b/%h/%b exp 0/00/0", tx_valid, tx_data, rx_overrun); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ex_ready); end
    rs1_idx = 4'd5; rs2_idx = 4'd15; #1;
    checks++; if (gr.x_rs1 !== 32'h0 || gr.x_rs2 !== 32'h0) begin
      errors++; $display("FAIL reset_rf got %h/%h exp 0/0", gr.x_rs1, gr.x_rs2); end
  endtask

  task automatic test_commit_basic();
    ex = '0; ex.pc = 32'h10; ex.w_rd = 1; ex.x_rd = 32'hDEADBEEF;
    ex.intr_en = 1; ex.intr_pc = 32'h80; ex.intr_vec = 8'h03;
    rd_idx = 4'd3; ex_valid = 1; rs1_idx = 4'd3; #1;
    checks++; if (gr.x_rs1 !== (BYPASS ? 32'hDEADBEEF : 32'h0)) begin
      errors++; $display("FAIL rf_same_cycle got %h exp %h", gr.x_rs1, BYPASS ? 32'hDEADBEEF : 32'h0); end
    tick(); #1;
    checks++; if (sr.pc !== 32'h10) begin errors++; $display("FAIL commit_pc got %h exp 00000010", sr.pc); end
    checks++; if (gr.x_rs1 !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_rd got %h exp deadbeef", gr.x_rs1); end
    checks++; if ({sr.intr_en, sr.intr_pc, sr.intr_vec} !== {1'b1, 32'h80, 8'h03}) begin
      errors++; $display("FAIL commit_intr got %b/%h/%h exp 1/00000080/03", sr.intr_en, sr.intr_pc, sr.intr_vec); end
  endtask

  task automatic test_x0();
    ex = '0; ex.w_rd = 1; ex.x_rd = 32'h5; rd_idx = 4'd0; ex_valid = 1; rs1_idx = 4'd0; #1;
    checks++; if (gr.x_rs1 !== 32'h0) begin errors++; $display("FAIL x0_same got %h exp 0", gr.x_rs1); end
    tick(); #1;
    checks++; if (gr.x_rs1 !== 32'h0) begin errors++; $display("FAIL x0_after got %h exp 0", gr.x_rs1); end
  endtask

  task automatic test_mem();
    ex = '0; ex.mem_w_req = 1; ex.mem_addr = 6'd63; ex.mem_val = 32'h11111111; ex_valid = 1;
    tick();
    ex.mem_val = 32'hA5A5A5A5; ex_valid = 1; mem_raddr = 6'd63; #1;
    checks++; if (gr.mem_val !== (BYPASS ? 32'hA5A5A5A5 : 32'h11111111)) begin
      errors++; $display("FAIL mem_same_cycle got %h exp %h", gr.mem_val, BYPASS ? 32'hA5A5A5A5 : 32'h11111111); end
    tick(); #1;
    checks++; if (gr.mem_val !== 32'hA5A5A5A5) begin errors++; $display("FAIL mem_after got %h exp a5a5a5a5", gr.mem_val); end
  endtask

  task automatic test_tx();
    tx_ready = 0;
    ex = '0; ex.pc = 32'h20; ex.w_req = 1; ex.w_data = 8'h41; ex_valid = 1;
    tick(); #1;
    checks++; if (tx_valid !== 1'b1 || sr.w_busy !== 1'b1 || tx_data !== 8'h41) begin
      errors++; $display("FAIL tx_load got %b/%b/%h exp 1/1/41", tx_valid, sr.w_busy, tx_data); end
    ex.pc = 32'h24; ex.w_data = 8'h42; ex_valid = 1; #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL tx_stall got %b exp 0", ex_ready); end
    tick(); #1;
    checks++; if (sr.pc !== 32'h20 || tx_data !== 8'h41) begin
      errors++; $display("FAIL tx_hold got %h/%h exp 00000020/41", sr.pc, tx_data); end
    tx_ready = 1; ex_valid = 1; #1;
    checks++; if (ex_ready !== 1'b1 || tx_data !== 8'h41) begin
      errors++; $display("FAIL tx_drain got %b/%h exp 1/41", ex_ready, tx_data); end
    tick(); #1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42 || sr.pc !== 32'h24) begin
      errors++; $display("FAIL tx_reload got %b/%h/%h exp 1/42/00000024", tx_valid, tx_data, sr.pc); end
    ex = '0; tick(); #1;
    checks++; if (tx_valid !== 1'b0 || sr.w_busy !== 1'b0) begin
      errors++; $display("FAIL tx_empty got %b/%b exp 0/0", tx_valid, sr.w_busy); end
  endtask

  task automatic test_rx();
    rx_valid = 1; rx_data = 8'h7A; tick(); #1;
    checks++; if (sr.irr !== 1'b1 || sr.r_data !== 8'h7A || rx_overrun !== 1'b0) begin
      errors++; $display("FAIL rx_first got %b/%h/%b exp 1/7a/0", sr.irr, sr.r_data, rx_overrun); end
    rx_valid = 1; rx_data = 8'h7B; tick(); #1;
    checks++; if (rx_overrun !== 1'b1 || sr.r_data !== 8'h7B) begin
      errors++; $display("FAIL rx_overrun got %b/%h exp 1/7b", rx_overrun, sr.r_data); end
    ex = '0; ex.ack = 1; ex_valid = 1; tick(); #1;
    checks++; if (sr.irr !== 1'b0) begin errors++; $display("FAIL rx_ack got %b exp 0", sr.irr); end
    rx_valid = 1; rx_data = 8'h7C; tick();
    ex_valid = 1; rx_valid = 1; rx_data = 8'h7D; tick(); #1;
    checks++; if (sr.irr !== 1'b1 || sr.r_data !== 8'h7D || rx_overrun !== 1'b1) begin
      errors++; $display("FAIL rx_ack_collide got %b/%h/%b exp 1/7d/1", sr.irr, sr.r_data, rx_overrun); end
  endtask

  task automatic test_reset_mid_stall();
    tx_ready = 0;
    ex = '0; ex.w_req = 1; ex.w_data = 8'h55; ex.pc = 32'h40; ex_valid = 1;
    tick();
    ex_valid = 1; #1;
    checks++; if (ex_ready !== 1'b0 || tx_valid !== 1'b1 || sr.irr !== 1'b1) begin
      errors++; $display("FAIL stall_setup got %b/%b/%b exp 0/1/1", ex_ready, tx_valid, sr.irr); end
    #1 rst_n = 0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h0 || sr.pc !== RESET_PC) begin
      errors++; $display("FAIL async_reset_tx got %b/%h/%h exp 0/00/%h", tx_valid, tx_data, sr.pc, RESET_PC); end
    checks++; if (ex_ready !== 1'b1 || sr.irr !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags got %b/%b/%b exp 1/0/0", ex_ready, sr.irr, rx_overrun); end
    model_reset();
    ex_valid = 0;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ex = '0;
      ex.pc = $urandom; ex.w_rd = ($urandom_range(0, 3) != 0); ex.x_rd = $urandom;
      ex.mem_w_req = ($urandom_range(0, 2) == 0); ex.mem_addr = 6'($urandom_range(0, 7));
      ex.mem_val = $urandom; ex.w_req = ($urandom_range(0, 2) == 0); ex.w_data = 8'($urandom);
      ex.ack = ($urandom_range(0, 3) == 0); ex.intr_en = 1'($urandom);
      ex.intr_pc = $urandom; ex.intr_vec = 8'($urandom);
      ex_valid = ($urandom_range(0, 3) != 0);
      rd_idx = 4'($urandom); rs1_idx = 4'($urandom); rs2_idx = 4'($urandom);
      mem_raddr = 6'($urandom_range(0, 7));
      rx_valid = ($urandom_range(0, 3) == 0); rx_data = 8'($urandom);
      tx_ready = 1'($urandom);
      #1;
      checks++; if (ex_ready !== ready_m()) begin
        errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, ex_ready, ready_m()); end
      checks++; if (gr.x_rs1 !== exp_reg(rs1_idx) || gr.x_rs2 !== exp_reg(rs2_idx)) begin
        errors++; $display("FAIL rnd_rf[%0d] got %h/%h exp %h/%h", n, gr.x_rs1, gr.x_rs2,
                           exp_reg(rs1_idx), exp_reg(rs2_idx)); end
      if (mem_visible(mem_raddr)) begin
        checks++; if (gr.mem_val !== exp_mem(mem_raddr)) begin
          errors++; $display("FAIL rnd_mem[%0d] got %h exp %h", n, gr.mem_val, exp_mem(mem_raddr)); end
      end
      checks++; if (sr !== exp_sr()) begin
        errors++; $display("FAIL rnd_sr[%0d] got %h exp %h", n, sr, exp_sr()); end
      checks++; if (tx_valid !== txv_m || rx_overrun !== ovr_m || (txv_m && tx_data !== txd_m)) begin
        errors++; $display("FAIL rnd_uart[%0d] got %b/%h/%b exp %b/%h/%b", n, tx_valid, tx_data,
                           rx_overrun, txv_m, txd_m, ovr_m); end
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    tx_ready = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1;
    test_commit_basic();
    test_x0();
    test_mem();
    test_tx();
    test_rx();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Commit stage directly downstream of execute; consumes one lib_cpu::EXECUTE record per handshake.
- Owns the architectural state: 16x32 register file, 64x32 data memory, and the lib_cpu::SPECIAL_REG fields.
- Owns the one-entry UART TX buffer and the RX byte latch.
- Drives the SPECIAL_REG and GENERAL_REG values consumed by decode on the next instruction.

Parameters:
- NREG, 16, register count (index width 4).
- NMEM, 64, data memory depth in words (address width 6, matches mem_addr).
- RESET_PC, 32'h0, pc after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute record valid.
- ex_ready  out  1  record accepted this cycle (commit happens).
- ex  in  $bits(lib_cpu::EXECUTE)  execute result record.
- rd_idx  in  4  destination register index for ex.
- rs1_idx  in  4  decode read index 1.
- rs2_idx  in  4  decode read index 2.
- mem_raddr  in  6  decode memory read address.
- sr  out  $bits(lib_cpu::SPECIAL_REG)  architectural special registers.
- gr  out  $bits(lib_cpu::GENERAL_REG)  x_rs1, x_rs2, mem_val for decode.
- rx_valid  in  1  UART RX byte strobe, one cycle.
- rx_data  in  8  UART RX byte.
- tx_valid  out  1  TX byte pending.
- tx_ready  in  1  UART TX accepts byte.
- tx_data  out  8  TX byte.
- rx_overrun  out  1  sticky: byte arrived while irr=1 and not acked.

Behaviour:
- commit = ex_valid & ex_ready.
- ex_ready = ~(ex.w_req & tx_valid & ~tx_ready): stalls only when TX buffer is full and not draining; otherwise 1, including when ex_valid=0.
- On commit:
  - rf[rd_idx] <= ex.x_rd if ex.w_rd and rd_idx != 0.
  - mem[ex.mem_addr] <= ex.mem_val if ex.mem_w_req.
  - sr.pc <= ex.pc.
  - sr.intr_en, sr.intr_pc, sr.intr_vec <= the corresponding ex fields.
- No commit: all state holds.
- Register 0 reads as 0 always; writes to it are dropped.
- Reads are combinational:
  - gr.x_rs1 = rf[rs1_idx], gr.x_rs2 = rf[rs2_idx].
  - gr.mem_val = mem[mem_raddr].
  - A write is visible from the cycle after commit (no bypass unless the optional feature is enabled).
- TX buffer:
  - Load on commit & ex.w_req: tx_valid<=1, tx_data<=ex.w_data.
  - Clear on tx_valid & tx_ready with no simultaneous load.
  - Simultaneous drain and load: old byte leaves, new byte loads, tx_valid stays 1.
  - sr.w_busy = tx_valid.
- RX latch:
  - rx_valid: irr<=1, r_data<=rx_data.
  - commit & ex.ack & ~rx_valid: irr<=0.
  - rx_valid same cycle as ack: new byte wins, irr stays 1.
  - rx_valid while irr=1 and no ack that cycle: rx_overrun<=1. Cleared only by reset.
- sr.irr and sr.r_data mirror the latch.
- Latency: record to visible state 1 cycle. tx_valid rises 1 cycle after the commit carrying w_req.
- Reset (async, any time, including mid-stall):
  - sr.pc=RESET_PC.
  - All other sr fields 0; tx_valid=0, tx_data=0, rx_overrun=0.
  - Register file zeroed.
  - Data memory not reset; contents undefined to the bench.
  - ex_ready follows its equation (1 after reset since tx_valid=0).

Optional Feature:
- Macro CPU_WB_BYPASS_EN.
- Defined: if commit & ex.w_rd & rd_idx!=0 & rs1_idx==rd_idx, gr.x_rs1=ex.x_rd in the same cycle; same rule for rs2. Also, if commit & ex.mem_w_req & mem_raddr==ex.mem_addr, gr.mem_val=ex.mem_val.
- Undefined: pure array reads; new value visible next cycle.

Decomposition:
- Add to lib_cpu:
  - REG_IDX_W=4, MEM_ADDR_W=6 constants.
  - typedef UART_TX_BUF (valid, data).
- Sub-module cpu_regfile: 16x32, 2 combinational read ports, 1 write port, x0 hardwired, bypass under CPU_WB_BYPASS_EN.
- Memory, TX buffer and RX latch stay inline.

Test Plan:
- Reset, then commit ex.pc=32'h10, w_rd=1, x_rd=32'hDEADBEEF, rd_idx=3 -> next cycle sr.pc=32'h10; rs1_idx=3 gives gr.x_rs1=32'hDEADBEEF.
- Commit w_rd=1, rd_idx=0, x_rd=32'h5 -> rs1_idx=0 reads 0.
- Commit mem_w_req=1, mem_addr=6'd63, mem_val=32'hA5A5A5A5 -> mem_raddr=63 reads 32'hA5A5A5A5 next cycle. Same cycle: new value with CPU_WB_BYPASS_EN defined, old value without it.
- Hold tx_ready=0; commit w_req=1, w_data=8'h41 -> tx_valid=1, sr.w_busy=1. Second w_req record -> ex_ready=0, pc unchanged. Raise tx_ready -> 8'h41 drains, the second byte loads that cycle, ex_ready=1.
- rx_valid with rx_data=8'h7A -> sr.irr=1, sr.r_data=8'h7A. Second rx_valid 8'h7B before ack -> rx_overrun=1, r_data=8'h7B. Commit ack=1 -> irr=0. Ack coincident with a new rx_valid -> irr stays 1.
- Assert rst_n=0 mid-stall (tx_valid=1, ex_ready=0) -> immediately tx_valid=0, sr.pc=RESET_PC, ex_ready=1, irr=0, rx_overrun=0.
